cpu_run_ctrl: RTL

- Run/step controller directly upstream of the control unit.
- Conditions the raw step push-button and run/step mode switch from the board, and drives the CU's step-execution level and its one-cycle next-instruction stimulus.
- Tracks CPU run state, including a sticky halt taken from the CU's halt output.
- Counts fetched instructions using the CU's IF-stage indication (C2).

---
 rtl/cpu_run_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step controller feeding the control unit: conditions the step button and
// mode switch, tracks run state with a sticky halt, and counts fetched instructions.
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int ICOUNT_W        = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_btn_step,
    input  logic                i_sw_step_mode,
    input  logic                i_ctrl_halt,
    input  logic                i_IF_stage,
    output logic                ctrl_step_execution,
    output logic                o_next_instr_stimulus,
    output logic [1:0]          o_run_state,
    output logic [ICOUNT_W-1:0] o_instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_STEP_WAIT = 2'b10,
        ST_HALTED    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_btn_s1, r_btn_s2, r_sw_s1, r_sw_s2;
    logic [CNT_W-1:0]    r_btn_cnt, r_sw_cnt, r_settle_cnt;
    logic                r_btn_db, r_btn_db_d, r_sw_db;
    logic                r_settled, r_sw_ref, r_if_d;
    logic                r_step_exec, r_stim;
    logic [ICOUNT_W-1:0] r_instr_count;
    logic                w_step_req, w_stim_nxt, w_settle_now, w_count_en;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_sw_s1  <= 1'b0;
            r_sw_s2  <= 1'b0;
        end else begin
            r_btn_s1 <= i_btn_step;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= i_sw_step_mode;
            r_sw_s2  <= r_sw_s1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_btn_cnt  <= '0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
        end else begin
            r_btn_db_d <= r_btn_db;
            if (r_btn_s2 == r_btn_db) begin
                r_btn_cnt <= '0;
            end else if (r_btn_cnt == CNT_LAST) begin
                r_btn_db  <= r_btn_s2;
                r_btn_cnt <= '0;
            end else begin
                r_btn_cnt <= r_btn_cnt + CNT_W'(1);
            end
        end
    end

    // Settling tracks raw stability of the synchronized switch, independent of the debouncer
    assign w_settle_now = !r_settled && (r_sw_s2 == r_sw_ref) && (r_settle_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_settled    <= 1'b0;
            r_sw_ref     <= 1'b0;
            r_settle_cnt <= '0;
        end else if (!r_settled) begin
            if (r_sw_s2 != r_sw_ref) begin
                r_sw_ref     <= r_sw_s2;
                r_settle_cnt <= '0;
            end else if (r_settle_cnt == CNT_LAST) begin
                r_settled <= 1'b1;
            end else begin
                r_settle_cnt <= r_settle_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sw_cnt <= '0;
            r_sw_db  <= 1'b0;
        end else if (w_settle_now) begin
            r_sw_db  <= r_sw_s2;
            r_sw_cnt <= '0;
        end else if (r_sw_s2 == r_sw_db) begin
            r_sw_cnt <= '0;
        end else if (r_sw_cnt == CNT_LAST) begin
            r_sw_db  <= r_sw_s2;
            r_sw_cnt <= '0;
        end else begin
            r_sw_cnt <= r_sw_cnt + CNT_W'(1);
        end
    end

    assign w_step_req = r_btn_db && !r_btn_db_d;

    always_comb begin
        w_state_nxt = r_state;
        if (i_ctrl_halt) begin
            w_state_nxt = ST_HALTED;
        end else begin
            case (r_state)
                ST_IDLE:      if (r_settled) w_state_nxt = r_sw_db ? ST_STEP_WAIT : ST_RUN;
                ST_RUN:       if (r_sw_db) w_state_nxt = ST_STEP_WAIT;
                ST_STEP_WAIT: if (!r_sw_db) w_state_nxt = ST_RUN;
                default:      w_state_nxt = ST_HALTED;
            endcase
        end
    end

    // Staying in STEP_WAIT implies no halt and no simultaneous exit to RUN
    assign w_stim_nxt = w_step_req && (r_state == ST_STEP_WAIT) && (w_state_nxt == ST_STEP_WAIT);
    assign w_count_en = i_IF_stage && !r_if_d && (r_instr_count != '1)
                        && ((r_state == ST_RUN) || (r_state == ST_STEP_WAIT));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_step_exec   <= 1'b1;
            r_stim        <= 1'b0;
            r_if_d        <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_exec <= (w_state_nxt != ST_RUN);
            r_stim      <= w_stim_nxt;
            r_if_d      <= i_IF_stage;
            if (w_count_en) r_instr_count <= r_instr_count + ICOUNT_W'(1);
        end
    end

    assign ctrl_step_execution   = r_step_exec;
    assign o_next_instr_stimulus = r_stim;
    assign o_run_state           = r_state;
    assign o_instr_count         = r_instr_count;

endmodule
